regfile_wrt_arbiter: RTL and testbench
======================================

# regfile_wrt_arbiter

Shares the register file's single write port between three writeback requesters: ALU result, load data, and link/CSR. Each requester has a one-entry holding slot and a valid/ready handshake. Occupied slots are granted round-robin, one per cycle, onto a registered write port that the register file samples on its negedge. Writes to r0 are dropped, same-address writes are kept in order by stalling, and a read-hazard query tells decode when a pending write targets a source register.

## Interface
- DATA_WIDTH, 32, write data width.
- ADDR_WIDTH, 5, register address width.
- clk  in  1  clock; all state updates on posedge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- reqNValid  in  1  (N=0,1,2) requester N offers a write.
- reqNAddr  in  ADDR_WIDTH  destination register of requester N.
- reqNData  in  DATA_WIDTH  write data of requester N.
- reqNReady  out  1  requester N's offer is accepted at this posedge if reqNValid=1.
- wrtEn  out  1  registered write enable to the register file.
- wrtAddr  out  ADDR_WIDTH  registered write address.
- wrtData  out  DATA_WIDTH  registered write data.
- grantId  out  2  index of the requester whose write is on the port; 2'd3 when idle.
- rdAddr  in  ADDR_WIDTH  decode source-register query.
- hazard  out  1  combinational; 1 when rdAddr≠0 matches an occupied slot or (wrtEn & wrtAddr).

## Operation
- State:
  - per-slot full flag, address and data;
  - lastGrant (2 bits, values 0..2);
  - output registers wrtEn, wrtAddr, wrtData, grantId.
- Grant selection (combinational from state only; never from valid inputs):
  - Scan occupied slots in the order (lastGrant+1)%3, (lastGrant+2)%3, lastGrant.
  - The first occupied slot found gets grantNow.
- conflictN is 1 when reqNAddr≠0 and either:
  - some slot j≠N is full, not granted this cycle, and has addr == reqNAddr; or
  - a lower-index requester j<N has reqjValid=1 and reqjAddr == reqNAddr.
- reqNReady = (~fullN | grantNowN) & ~conflictN.
- Acceptance (reqNValid & reqNReady at posedge):
  - Addr ≠ 0: slot N is loaded and fullN is set.
  - Addr = 0: the request is consumed and discarded; slot N is not filled (it still clears if it was granted this cycle).
- Grant (at posedge):
  - Output registers load the granted slot's address and data; wrtEn=1, grantId=slot index.
  - The slot clears unless it is refilled in the same edge.
  - lastGrant is set to the granted index.
- No grant: wrtEn=0, grantId=3; wrtAddr and wrtData hold their previous values; lastGrant holds.
- Ordering guarantees:
  - Writes to the same register are never reordered, because of the conflict stall.
  - Writes to different registers may be reordered.

## Timing
- Reset values (asynchronous):
  - all full flags 0;
  - wrtEn=0, wrtAddr=0, wrtData=0, grantId=3;
  - lastGrant=2, so slot 0 has first priority.
- Right after reset, all reqNReady=1 except where a conflict applies.
- Latency: accepted at posedge E → wrtEn=1 after posedge E+1 at the earliest; the data is written at the register file's negedge in that cycle.
- Throughput:
  - one write per cycle total;
  - each requester can sustain one write per 3 cycles under full contention, and one per cycle when it is the only requester.
- Same-edge refill: a slot granted at edge E can accept a new request at edge E; the old and new contents stay distinct.
- Reset asserted mid-operation: all pending slot contents are lost; wrtEn drops immediately (not at the next edge).
- hazard is purely combinational and has no latency.

## Test plan
- Reset, then req0 only: addr=5, data=0xDEADBEEF, valid for 1 cycle.
  - Expect: wrtEn=1, wrtAddr=5, wrtData=0xDEADBEEF, grantId=0 in the cycle after the accept edge; wrtEn=0 on the following cycle.
- All three valid continuously with addrs 1, 2, 3:
  - Expect grantId sequence 0,1,2,0,1,2.
  - Expect each reqNReady to pulse once per 3 cycles.
  - Expect no lost or duplicated data (scoreboard).
- req0 addr=7, data=0x11 and req1 addr=7, data=0x22 in the same cycle:
  - Expect req1Ready=0 while req0 is pending.
  - Expect writes in order 0x11 then 0x22 to r7.
- req2 addr=0, data=0xFF:
  - Expect req2Ready=1 and no wrtEn pulse.
  - Expect hazard=0 for rdAddr=0.
- Slot 1 holds addr 9 and rdAddr=9:
  - Expect hazard=1 until the cycle wrtEn drops for r9; then hazard=0 with rdAddr=9.
- Reset asserted while all slots are full and wrtEn=1:
  - Expect wrtEn=0 and grantId=3 immediately.
  - Expect no writes after reset releases until a new accept.

Source files
------------

// File: rtl/regfile_wrt_arbiter.sv
// regfile_wrt_arbiter
// Shares the register file's single write port between three writeback
// requesters (0: ALU result, 1: load data, 2: link/CSR). Each requester owns a
// one-entry holding slot behind a valid/ready handshake. Occupied slots are
// granted round-robin, one per cycle, onto a registered write port that the
// register file samples on its negedge.
//
// Ports:
//   clk, reset                 posedge clock, asynchronous active-high reset
//   reqNValid/Addr/Data (N=0..2) write offer from requester N
//   reqNReady                  offer is accepted at this posedge when valid
//   wrtEn/wrtAddr/wrtData      registered write port to the register file
//   grantId                    requester on the port, 2'd3 when idle
//   rdAddr, hazard             decode source-register query (combinational)
module regfile_wrt_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req0Valid,
  input  logic [ADDR_WIDTH-1:0] req0Addr,
  input  logic [DATA_WIDTH-1:0] req0Data,
  output logic                  req0Ready,
  input  logic                  req1Valid,
  input  logic [ADDR_WIDTH-1:0] req1Addr,
  input  logic [DATA_WIDTH-1:0] req1Data,
  output logic                  req1Ready,
  input  logic                  req2Valid,
  input  logic [ADDR_WIDTH-1:0] req2Addr,
  input  logic [DATA_WIDTH-1:0] req2Data,
  output logic                  req2Ready,
  output logic                  wrtEn,
  output logic [ADDR_WIDTH-1:0] wrtAddr,
  output logic [DATA_WIDTH-1:0] wrtData,
  output logic [1:0]            grantId,
  input  logic [ADDR_WIDTH-1:0] rdAddr,
  output logic                  hazard
);

  logic [2:0]            req_valid;
  logic [ADDR_WIDTH-1:0] req_addr [3];
  logic [DATA_WIDTH-1:0] req_data [3];

  logic [2:0]            full;
  logic [ADDR_WIDTH-1:0] slot_addr [3];
  logic [DATA_WIDTH-1:0] slot_data [3];
  logic [1:0]            last_grant;

  logic [1:0]            cand1;
  logic [1:0]            cand2;
  logic                  grant_vld;
  logic [1:0]            grant_idx;
  logic [2:0]            grant_now;
  logic [2:0]            conflict;
  logic [2:0]            ready;
  logic [2:0]            accept;
  logic [2:0]            load;

  assign req_valid   = {req2Valid, req1Valid, req0Valid};
  assign req_addr[0] = req0Addr;
  assign req_addr[1] = req1Addr;
  assign req_addr[2] = req2Addr;
  assign req_data[0] = req0Data;
  assign req_data[1] = req1Data;
  assign req_data[2] = req2Data;

  assign req0Ready = ready[0];
  assign req1Ready = ready[1];
  assign req2Ready = ready[2];

  function automatic logic [1:0] next_idx(input logic [1:0] i);
    return (i == 2'd2) ? 2'd0 : i + 2'd1;
  endfunction

  // Round-robin pick from slot state only, so ready never depends on the
  // valid inputs through the grant path.
  always_comb begin
    cand1     = next_idx(last_grant);
    cand2     = next_idx(cand1);
    grant_vld = 1'b1;
    grant_idx = last_grant;
    if (full[cand1])           grant_idx = cand1;
    else if (full[cand2])      grant_idx = cand2;
    else if (full[last_grant]) grant_idx = last_grant;
    else                       grant_vld = 1'b0;
    grant_now = grant_vld ? (3'b001 << grant_idx) : 3'b000;
  end

  // A request stalls while an older write to the same register is still
  // waiting in another slot, or while a lower-index requester offers the
  // same register this cycle. A slot leaving on the port this cycle does not
  // block, since its write lands before the new one can be granted.
  always_comb begin
    conflict = '0;
    ready    = '0;
    accept   = '0;
    load     = '0;
    for (int n = 0; n < 3; n++) begin
      for (int j = 0; j < 3; j++) begin
        if (j != n && full[j] && !grant_now[j] && slot_addr[j] == req_addr[n])
          conflict[n] = 1'b1;
        if (j < n && req_valid[j] && req_addr[j] == req_addr[n])
          conflict[n] = 1'b1;
      end
      if (req_addr[n] == '0)
        conflict[n] = 1'b0;
      ready[n]  = (~full[n] | grant_now[n]) & ~conflict[n];
      accept[n] = req_valid[n] & ready[n];
      // r0 writes are consumed but never occupy a slot.
      load[n]   = accept[n] & (req_addr[n] != '0);
    end
  end

  always_comb begin
    hazard = 1'b0;
    if (rdAddr != '0) begin
      for (int j = 0; j < 3; j++)
        if (full[j] && slot_addr[j] == rdAddr)
          hazard = 1'b1;
      if (wrtEn && wrtAddr == rdAddr)
        hazard = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      full       <= '0;
      last_grant <= 2'd2;
      wrtEn      <= 1'b0;
      wrtAddr    <= '0;
      wrtData    <= '0;
      grantId    <= 2'd3;
    end else begin
      // Refill wins over the clear so a slot granted this edge can take a
      // new request in the same edge.
      for (int n = 0; n < 3; n++) begin
        if (load[n])           full[n] <= 1'b1;
        else if (grant_now[n]) full[n] <= 1'b0;
      end
      if (grant_vld) begin
        wrtEn      <= 1'b1;
        wrtAddr    <= slot_addr[grant_idx];
        wrtData    <= slot_data[grant_idx];
        grantId    <= grant_idx;
        last_grant <= grant_idx;
      end else begin
        wrtEn   <= 1'b0;
        grantId <= 2'd3;
      end
    end
  end

  // Slot payload carries no reset; the full flags qualify it.
  always_ff @(posedge clk) begin
    for (int n = 0; n < 3; n++) begin
      if (load[n]) begin
        slot_addr[n] <= req_addr[n];
        slot_data[n] <= req_data[n];
      end
    end
  end

endmodule

// File: tb/tb_regfile_wrt_arbiter.sv
// Testbench for regfile_wrt_arbiter: directed steps with a write scoreboard.
module tb_regfile_wrt_arbiter;
  localparam int DW = 32;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          reset;
  logic          req0Valid, req1Valid, req2Valid;
  logic [AW-1:0] req0Addr, req1Addr, req2Addr;
  logic [DW-1:0] req0Data, req1Data, req2Data;
  logic          req0Ready, req1Ready, req2Ready;
  logic          wrtEn;
  logic [AW-1:0] wrtAddr;
  logic [DW-1:0] wrtData;
  logic [1:0]    grantId;
  logic [AW-1:0] rdAddr;
  logic          hazard;
  logic [2:0]    rdy;

  int n_cmp = 0;
  int n_err = 0;
  logic [63:0] sbq [$];
  int m [3];

  always #5 clk = ~clk;

  assign rdy = {req2Ready, req1Ready, req0Ready};

  regfile_wrt_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .reset(reset),
    .req0Valid(req0Valid), .req0Addr(req0Addr), .req0Data(req0Data), .req0Ready(req0Ready),
    .req1Valid(req1Valid), .req1Addr(req1Addr), .req1Data(req1Data), .req1Ready(req1Ready),
    .req2Valid(req2Valid), .req2Addr(req2Addr), .req2Data(req2Data), .req2Ready(req2Ready),
    .wrtEn(wrtEn), .wrtAddr(wrtAddr), .wrtData(wrtData), .grantId(grantId),
    .rdAddr(rdAddr), .hazard(hazard)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  function automatic logic [63:0] pk(input logic [1:0] id, input logic [AW-1:0] a,
                                     input logic [DW-1:0] d);
    return {25'b0, id, a, d};
  endfunction

  function automatic logic [DW-1:0] td(input int n, input int k);
    return 32'hA000_0000 | (32'(n) << 16) | 32'(k);
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic settle;
    #1;
  endtask

  task automatic drive(input int n, input logic v, input logic [AW-1:0] a, input logic [DW-1:0] d);
    case (n)
      0: begin req0Valid = v; req0Addr = a; req0Data = d; end
      1: begin req1Valid = v; req1Addr = a; req1Data = d; end
      default: begin req2Valid = v; req2Addr = a; req2Data = d; end
    endcase
  endtask

  // Scoreboard: every write seen on the port must be the next expected one.
  always @(negedge clk) begin
    if (!reset && wrtEn) begin
      chk("sb_write_expected", 64'(sbq.size() != 0), 64'(1));
      if (sbq.size() != 0)
        chk("sb_write", 64'({grantId, wrtAddr, wrtData}), sbq.pop_front());
    end
  end

  initial begin
    reset = 1'b1;
    rdAddr = '0;
    for (int n = 0; n < 3; n++) drive(n, 1'b0, '0, '0);
    #1;
    chk("rst_wrtEn", 64'(wrtEn), 64'(0));
    chk("rst_grantId", 64'(grantId), 64'(3));
    chk("rst_wrtAddr", 64'(wrtAddr), 64'(0));
    chk("rst_wrtData", 64'(wrtData), 64'(0));
    chk("rst_ready", 64'(rdy), 64'(3'b111));
    chk("rst_hazard", 64'(hazard), 64'(0));
    tick;
    tick;
    reset = 1'b0;

    // Single request from requester 0.
    drive(0, 1'b1, 5'd5, 32'hDEADBEEF);
    sbq.push_back(pk(2'd0, 5'd5, 32'hDEADBEEF));
    settle;
    chk("t1_ready0", 64'(req0Ready), 64'(1));
    tick;
    drive(0, 1'b0, '0, '0);
    rdAddr = 5'd5;
    settle;
    chk("t1_wrtEn_pending", 64'(wrtEn), 64'(0));
    chk("t1_hazard_slot", 64'(hazard), 64'(1));
    tick;
    chk("t1_wrtEn", 64'(wrtEn), 64'(1));
    chk("t1_wrtAddr", 64'(wrtAddr), 64'(5));
    chk("t1_wrtData", 64'(wrtData), 64'(32'hDEADBEEF));
    chk("t1_grantId", 64'(grantId), 64'(0));
    tick;
    chk("t1_wrtEn_drop", 64'(wrtEn), 64'(0));
    rdAddr = '0;

    // Full contention, restarting from reset so slot 0 has first priority.
    reset = 1'b1;
    #1;
    reset = 1'b0;
    for (int n = 0; n < 3; n++) begin
      m[n] = 0;
      drive(n, 1'b1, 5'(n + 1), td(n, 0));
      sbq.push_back(pk(2'(n), 5'(n + 1), td(n, 0)));
    end
    settle;
    chk("t2_ready_all", 64'(rdy), 64'(3'b111));
    tick;
    for (int n = 0; n < 3; n++) begin
      m[n] = 1;
      drive(n, 1'b1, 5'(n + 1), td(n, 1));
    end
    for (int k = 1; k <= 6; k++) begin
      int n;
      n = (k - 1) % 3;
      sbq.push_back(pk(2'(n), 5'(n + 1), td(n, m[n])));
      settle;
      chk("t2_ready_pulse", 64'(rdy), 64'(3'b001 << n));
      tick;
      chk("t2_wrtEn", 64'(wrtEn), 64'(1));
      chk("t2_grantId", 64'(grantId), 64'(n));
      m[n] = m[n] + 1;
      drive(n, 1'b1, 5'(n + 1), td(n, m[n]));
    end
    for (int n = 0; n < 3; n++) drive(n, 1'b0, '0, '0);
    repeat (4) tick;
    chk("t2_idle", 64'(wrtEn), 64'(0));

    // Same register offered by requesters 0 and 1 in one cycle.
    drive(0, 1'b1, 5'd7, 32'h11);
    drive(1, 1'b1, 5'd7, 32'h22);
    sbq.push_back(pk(2'd0, 5'd7, 32'h11));
    settle;
    chk("t3_ready_same_cycle", 64'(rdy), 64'(3'b101));
    tick;
    drive(0, 1'b0, '0, '0);
    sbq.push_back(pk(2'd1, 5'd7, 32'h22));
    settle;
    chk("t3_ready1_while_granted", 64'(req1Ready), 64'(1));
    tick;
    drive(1, 1'b0, '0, '0);
    chk("t3_first_data", 64'(wrtData), 64'(32'h11));
    chk("t3_first_id", 64'(grantId), 64'(0));
    tick;
    chk("t3_second_data", 64'(wrtData), 64'(32'h22));
    chk("t3_second_addr", 64'(wrtAddr), 64'(7));
    tick;
    chk("t3_idle", 64'(wrtEn), 64'(0));

    // Stall on a waiting (not yet granted) slot with the same register.
    drive(0, 1'b1, 5'd12, 32'hA);
    drive(2, 1'b1, 5'd13, 32'hB);
    sbq.push_back(pk(2'd2, 5'd13, 32'hB));
    sbq.push_back(pk(2'd0, 5'd12, 32'hA));
    tick;
    drive(0, 1'b0, '0, '0);
    drive(2, 1'b0, '0, '0);
    drive(1, 1'b1, 5'd12, 32'hC);
    rdAddr = 5'd12;
    settle;
    chk("t3b_ready1_stall", 64'(req1Ready), 64'(0));
    chk("t3b_hazard", 64'(hazard), 64'(1));
    tick;
    chk("t3b_grant2", 64'(grantId), 64'(2));
    chk("t3b_ready1_release", 64'(req1Ready), 64'(1));
    sbq.push_back(pk(2'd1, 5'd12, 32'hC));
    tick;
    drive(1, 1'b0, '0, '0);
    chk("t3b_grant0", 64'(grantId), 64'(0));
    tick;
    chk("t3b_grant1", 64'(grantId), 64'(1));
    chk("t3b_data_c", 64'(wrtData), 64'(32'hC));
    tick;
    chk("t3b_idle", 64'(wrtEn), 64'(0));

    // Write to r0 is consumed and dropped.
    drive(2, 1'b1, 5'd0, 32'hFF);
    rdAddr = 5'd0;
    settle;
    chk("t4_ready2", 64'(req2Ready), 64'(1));
    chk("t4_hazard_r0", 64'(hazard), 64'(0));
    tick;
    drive(2, 1'b0, '0, '0);
    chk("t4_no_write", 64'(wrtEn), 64'(0));
    chk("t4_grant_idle", 64'(grantId), 64'(3));
    tick;
    chk("t4_no_write_later", 64'(wrtEn), 64'(0));

    // Hazard tracking for r9 held in slot 1.
    drive(1, 1'b1, 5'd9, 32'h99);
    rdAddr = 5'd9;
    sbq.push_back(pk(2'd1, 5'd9, 32'h99));
    settle;
    chk("t5_hazard_before", 64'(hazard), 64'(0));
    tick;
    drive(1, 1'b0, '0, '0);
    settle;
    chk("t5_hazard_slot", 64'(hazard), 64'(1));
    tick;
    chk("t5_wrtAddr", 64'(wrtAddr), 64'(9));
    chk("t5_hazard_port", 64'(hazard), 64'(1));
    tick;
    chk("t5_wrtEn_drop", 64'(wrtEn), 64'(0));
    chk("t5_hazard_clear", 64'(hazard), 64'(0));

    // Reset while all slots are full and a write is on the port.
    drive(0, 1'b1, 5'd20, 32'h2020);
    drive(1, 1'b1, 5'd21, 32'h2121);
    drive(2, 1'b1, 5'd22, 32'h2222A);
    settle;
    chk("t6_ready_all", 64'(rdy), 64'(3'b111));
    tick;
    drive(0, 1'b0, '0, '0);
    drive(1, 1'b0, '0, '0);
    drive(2, 1'b1, 5'd22, 32'h2222B);
    settle;
    chk("t6_ready2_refill", 64'(req2Ready), 64'(1));
    tick;
    drive(2, 1'b0, '0, '0);
    chk("t6_wrtEn_before", 64'(wrtEn), 64'(1));
    chk("t6_wrtData_before", 64'(wrtData), 64'(32'h2222A));
    chk("t6_grant_before", 64'(grantId), 64'(2));
    reset = 1'b1;
    rdAddr = 5'd20;
    #1;
    chk("t6_wrtEn_async", 64'(wrtEn), 64'(0));
    chk("t6_grant_async", 64'(grantId), 64'(3));
    chk("t6_hazard_cleared", 64'(hazard), 64'(0));
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick;
      chk("t6_no_write_after_reset", 64'(wrtEn), 64'(0));
    end
    drive(0, 1'b1, 5'd3, 32'h1234);
    sbq.push_back(pk(2'd0, 5'd3, 32'h1234));
    tick;
    drive(0, 1'b0, '0, '0);
    tick;
    chk("t6_new_write", 64'(wrtEn), 64'(1));
    chk("t6_new_data", 64'(wrtData), 64'(32'h1234));
    tick;
    tick;
    chk("sb_drained", 64'(sbq.size()), 64'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
